// File: rtl/pe_fg_array.sv
// LANES-wide polar SC node processor: F (min-sum) / G (partial-sum add) with symmetric
// saturation, two register stages under valid/ready backpressure, and a saturation-event counter.

module pe_fg_lane #(
    parameter int LLR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic             s1_mode,
    input  logic [LLR_W-1:0] a,
    input  logic [LLR_W-1:0] b,
    input  logic             u,
    output logic [LLR_W-1:0] res,
    output logic             sat
);
    localparam logic [LLR_W-1:0] MIN_CODE = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic [LLR_W-2:0] MAXV     = '1;
    localparam logic [LLR_W-1:0] POS_MAX  = {1'b0, MAXV};
    localparam logic [LLR_W-1:0] NEG_MAX  = -POS_MAX;
    localparam logic [LLR_W:0]   POS_MAX_X = {1'b0, POS_MAX};
    localparam logic [LLR_W:0]   NEG_MAX_X = {1'b1, NEG_MAX};

    typedef struct packed {
        logic [LLR_W-2:0] abs_a;
        logic [LLR_W-2:0] abs_b;
        logic             sgn;
        logic             fsat;
        logic [LLR_W:0]   sum;
    } s1_t;

    s1_t              s1_d, s1_q;
    logic [LLR_W-1:0] neg_a, neg_b;
    logic             a_min, b_min;
    logic [LLR_W:0]   a_x, b_x;

    // Stage 1: both F and G precomputes are captured; the beat's mode picks in stage 2.
    always_comb begin
        a_min      = (a == MIN_CODE);
        b_min      = (b == MIN_CODE);
        neg_a      = -a;
        neg_b      = -b;
        a_x        = {a[LLR_W-1], a};
        b_x        = {b[LLR_W-1], b};
        s1_d.abs_a = a_min ? MAXV : (a[LLR_W-1] ? neg_a[LLR_W-2:0] : a[LLR_W-2:0]);
        s1_d.abs_b = b_min ? MAXV : (b[LLR_W-1] ? neg_b[LLR_W-2:0] : b[LLR_W-2:0]);
        s1_d.sgn   = a[LLR_W-1] ^ b[LLR_W-1];
        s1_d.fsat  = a_min | b_min;
        s1_d.sum   = u ? (b_x - a_x) : (b_x + a_x);
    end

    logic [LLR_W-2:0] mag;
    logic [LLR_W-1:0] mag_x, f_res, g_res;
    logic             g_hi, g_lo;

    // Negating a zero magnitude still yields 0, so no negative-zero code can appear.
    always_comb begin
        mag   = (s1_q.abs_a < s1_q.abs_b) ? s1_q.abs_a : s1_q.abs_b;
        mag_x = {1'b0, mag};
        f_res = s1_q.sgn ? -mag_x : mag_x;
        g_hi  = $signed(s1_q.sum) > $signed(POS_MAX_X);
        g_lo  = $signed(s1_q.sum) < $signed(NEG_MAX_X);
        g_res = g_hi ? POS_MAX : (g_lo ? NEG_MAX : s1_q.sum[LLR_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            res  <= '0;
            sat  <= 1'b0;
        end else begin
            if (s1_en) s1_q <= s1_d;
            if (s2_en) begin
                res <= s1_mode ? g_res : f_res;
                sat <= s1_mode ? (g_hi | g_lo) : s1_q.fsat;
            end
        end
    end
endmodule

module pe_fg_array #(
    parameter int LLR_W = 6,
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*LLR_W-1:0] in_llr_a,
    input  logic [LANES*LLR_W-1:0] in_llr_b,
    input  logic [LANES-1:0]       in_u,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*LLR_W-1:0] out_llr,
    output logic                   out_last,
    input  logic                   sat_cnt_clr,
    output logic [CNT_W-1:0]       sat_cnt
);
    localparam int STAGES = 2;
    localparam int NW     = $clog2(LANES + 1);
    localparam int CW1    = CNT_W + 1;

    logic [STAGES:1]                vld_pipe;
    logic                           s1_adv, s2_adv, s1_en, s2_en;
    logic                           s1_mode, s1_last;
    logic [LANES-1:0][LLR_W-1:0]    a_arr, b_arr, res_arr;
    logic [LANES-1:0]               lane_sat;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign s1_en     = s1_adv && in_valid;
    assign s2_en     = s2_adv && vld_pipe[1];
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];
    assign a_arr     = in_llr_a;
    assign b_arr     = in_llr_b;
    assign out_llr   = res_arr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (s1_en) begin
                s1_mode <= in_mode;
                s1_last <= in_last;
            end
            if (s2_en) out_last <= s1_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_fg_lane #(.LLR_W(LLR_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s1_en   (s1_en),
            .s2_en   (s2_en),
            .s1_mode (s1_mode),
            .a       (a_arr[i]),
            .b       (b_arr[i]),
            .u       (in_u[i]),
            .res     (res_arr[i]),
            .sat     (lane_sat[i])
        );
    end

    logic [NW-1:0]  n_sat;
    logic [CNT_W:0] cnt_sum;

    always_comb begin
        n_sat = '0;
        for (int i = 0; i < LANES; i++) n_sat = n_sat + NW'(lane_sat[i]);
        cnt_sum = {1'b0, sat_cnt} + CW1'(n_sat);
    end

    // Clear takes priority, so a beat leaving on the clear edge is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      sat_cnt <= '0;
        else if (sat_cnt_clr)            sat_cnt <= '0;
        else if (out_valid && out_ready) sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_pe_fg_array.sv
// Scoreboarded bench for pe_fg_array: directed plan cases plus randomized F/G traffic
// under random backpressure, checked against an integer reference model.

module tb_pe_fg_array;
    localparam int W    = 6;
    localparam int L    = 4;
    localparam int CW   = 16;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_ready, in_mode = 1'b0, in_last = 1'b0;
    logic [L*W-1:0]   in_llr_a = '0, in_llr_b = '0, out_llr;
    logic [L-1:0]     in_u = '0;
    logic             out_valid, out_ready = 1'b0, out_last, sat_cnt_clr = 1'b0;
    logic [CW-1:0]    sat_cnt;

    pe_fg_array #(.LLR_W(W), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_llr_a(in_llr_a), .in_llr_b(in_llr_b), .in_u(in_u),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_llr(out_llr), .out_last(out_last), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] llr;
        logic           last;
        int             nsat;
        int             acc;
        bit             chk_lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0, exp_cnt = 0;
    int   ta[L], tb[L];
    bit   tu[L];
    bit   rnd_on;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int ref_lane(input bit mode, input int a, input int b, input bit u,
                                    output bit sat);
        int aa, ab, mag, s, r;
        if (!mode) begin
            aa  = (a == -MAXV - 1) ? MAXV : (a < 0 ? -a : a);
            ab  = (b == -MAXV - 1) ? MAXV : (b < 0 ? -b : b);
            mag = (aa < ab) ? aa : ab;
            r   = ((a < 0) != (b < 0)) ? -mag : mag;
            sat = (a == -MAXV - 1) || (b == -MAXV - 1);
        end else begin
            s   = u ? b - a : b + a;
            r   = (s > MAXV) ? MAXV : ((s < -MAXV) ? -MAXV : s);
            sat = (r != s);
        end
        return r;
    endfunction

    task automatic send_beat(input bit mode, input bit last, input bit chk);
        exp_t           e;
        logic [L*W-1:0] pa, pb, pl;
        int             r;
        bit             s, ok;
        e.nsat = 0;
        for (int i = 0; i < L; i++) begin
            r = ref_lane(mode, ta[i], tb[i], tu[i], s);
            pa[i*W +: W] = W'(ta[i]);
            pb[i*W +: W] = W'(tb[i]);
            pl[i*W +: W] = W'(r);
            e.nsat += int'(s);
        end
        e.llr = pl; e.last = last; e.chk_lat = chk; e.acc = 0;
        in_mode = mode; in_last = last; in_llr_a = pa; in_llr_b = pb;
        for (int i = 0; i < L; i++) in_u[i] = tu[i];
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                e.acc = cyc;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && q.size() > 0; k++) @(negedge clk);
        check("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < L; i++) begin
            ta[i] = ($urandom_range(0, 7) == 0) ? -MAXV - 1 : int'($urandom_range(0, 63)) - 32;
            tb[i] = ($urandom_range(0, 7) == 0) ? -MAXV - 1 : int'($urandom_range(0, 63)) - 32;
            tu[i] = 1'($urandom_range(0, 1));
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every output transfer and tracks the expected counter.
    initial forever begin
        exp_t e;
        int   n;
        bit   xfer;
        @(negedge clk);
        if (!rst_n) begin
            exp_cnt = 0;
        end else begin
            check("sat_cnt", sat_cnt, exp_cnt);
            n = 0;
            xfer = out_valid && out_ready;
            if (xfer) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_llr);
                end else begin
                    e = q.pop_front();
                    check("out_llr", out_llr, e.llr);
                    check("out_last", out_last, e.last);
                    if (e.chk_lat) check("latency", cyc - e.acc, 2);
                    n = e.nsat;
                end
            end
            if (sat_cnt_clr) exp_cnt = 0;
            else if (xfer) exp_cnt = (exp_cnt + n > CMAX) ? CMAX : exp_cnt + n;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L*W-1:0] held;
        bit             have;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_llr", out_llr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed F, F-saturating and G beats with an empty pipe.
        out_ready = 1'b1;
        ta = '{-5, 12, -9, 0};    tb = '{7, -3, -9, -17};  tu = '{0, 0, 0, 0};
        send_beat(1'b0, 1'b1, 1'b1);
        drain();
        check("t1_sat_cnt", sat_cnt, 0);
        ta = '{-32, -32, 31, -32}; tb = '{-32, 10, -32, 0};
        send_beat(1'b0, 1'b0, 1'b1);
        drain();
        check("t2_sat_cnt", sat_cnt, 4);
        ta = '{20, 20, -32, -32};  tb = '{20, 20, -32, 5};  tu = '{0, 1, 0, 1};
        send_beat(1'b1, 1'b1, 1'b1);
        drain();
        check("t3_sat_cnt", sat_cnt, 7);

        // Five back-to-back beats against a 4-cycle stall.
        out_ready = 1'b0;
        have = 1'b0;
        held = '0;
        fork
            for (int j = 0; j < 5; j++) begin
                rand_operands();
                send_beat(1'(j % 2), (j == 1) || (j == 4), 1'b0);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (k >= 2) check("stall_in_ready", in_ready, 0);
                    if (out_valid) begin
                        if (have) check("stall_out_stable", out_llr, held);
                        held = out_llr;
                        have = 1'b1;
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure and gaps.
        rnd_on = 1'b1;
        fork
            begin
                for (int j = 0; j < 300; j++) begin
                    rand_operands();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Counter boundaries.
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1 sat_cnt_clr = 1'b0;
        check("clr_sat_cnt", sat_cnt, 0);
        ta = '{-32, -32, -32, -32}; tb = '{-32, -32, -32, -32};
        for (int j = 0; j < 16383; j++) send_beat(1'b0, 1'b0, 1'b0);
        ta = '{-32, -32, 1, 1};     tb = '{1, 1, 1, 1};
        send_beat(1'b0, 1'b0, 1'b0);
        drain();
        check("preload_fffe", sat_cnt, 16'hFFFE);
        ta = '{-32, -32, -32, -32};
        send_beat(1'b0, 1'b0, 1'b0);
        drain();
        check("sat_at_ffff", sat_cnt, 16'hFFFF);
        send_beat(1'b0, 1'b1, 1'b0);
        drain();
        check("sat_hold_ffff", sat_cnt, 16'hFFFF);
        send_beat(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1 sat_cnt_clr = 1'b1;
        @(posedge clk); #1 sat_cnt_clr = 1'b0;
        check("clr_wins", sat_cnt, 0);
        check("clr_beat_delivered", q.size(), 0);

        // Asynchronous reset with both stages full.
        send_beat(1'b0, 1'b0, 1'b0);
        drain();
        out_ready = 1'b0;
        rand_operands();
        send_beat(1'b1, 1'b0, 1'b0);
        rand_operands();
        send_beat(1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_llr", out_llr, 0);
        check("mid_rst_sat_cnt", sat_cnt, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        ta = '{-7, 3, 15, -32}; tb = '{9, -3, 2, 4}; tu = '{0, 1, 1, 0};
        send_beat(1'b1, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_fg_array.md
Name: pe_fg_array

Overview:
Parametrised, pipelined successor to the single-node F block. The block processes LANES successive-cancellation node operations in parallel each beat. It supports both F (min-sum) and G (partial-sum-controlled add) modes, uses symmetric saturation, and provides a valid/ready stream interface with backpressure. It sits between the LLR memory read path and write-back in the polar decoder datapath. A saturation counter is included for fixed-point width tuning.

Parameters:
LLR_W, 6, two's-complement LLR width for inputs and outputs (>=3)
LANES, 8, number of parallel PE lanes (>=1)
CNT_W, 16, width of the saturation event counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_mode  input  1  0 = F, 1 = G (applies to all lanes of the beat)
in_llr_a  input  LANES*LLR_W  operand a; lane i at bits [i*LLR_W +: LLR_W]
in_llr_b  input  LANES*LLR_W  operand b; same packing
in_u  input  LANES  partial-sum bit per lane (G mode only, ignored in F)
in_last  input  1  end-of-node marker, carried with the beat
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_llr  output  LANES*LLR_W  results; same packing
out_last  output  1  in_last delayed with its beat
sat_cnt_clr  input  1  synchronous clear of sat_cnt
sat_cnt  output  CNT_W  saturating count of saturated lane results delivered

Behaviour:
- Define MAXV = 2^(LLR_W-1)-1. All outputs lie in the symmetric range [-MAXV, +MAXV]. The code -2^(LLR_W-1) is never produced.
- F lane: |x| is computed with symmetric saturation, so the most negative input maps to MAXV. Result magnitude = min(|a|,|b|); on a tie, either operand gives the same value. Sign = sign(a) XOR sign(b). A zero magnitude yields 0, never a negative zero code. A lane is flagged saturated if either input equals -2^(LLR_W-1).
- G lane: sum = b + (u ? -a : a), computed at LLR_W+1 bits with no internal overflow. The sum is clamped to [-MAXV, +MAXV]. The lane is flagged saturated if the clamp changed the value.
- Pipeline: two register stages.
  - S1 registers: operands, mode, u, last, and the precomputed abs/sign or widened sum.
  - S2 registers: final out_llr, out_last, and per-lane saturation flags.
- Latency: 2 cycles from accepted input to out_valid, with no stall. Throughput: 1 beat per cycle.
- Handshake: a beat transfers when valid && ready on either interface.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no path from in_valid to in_ready).
- While out_valid=1 and out_ready=0: out_llr and out_last hold stable, and at most 2 beats are buffered (S1 and S2). in_ready=0 only when both stages are full and out_ready=0.
- Bubbles collapse. Beat order is strictly preserved. No beat is dropped or duplicated.
- sat_cnt:
  - On each output transfer (out_valid && out_ready), add the number of flagged lanes in that beat.
  - Saturate at 2^CNT_W-1; no wrap.
  - sat_cnt_clr=1 sets the counter to 0 on the next edge. Clear wins over a simultaneous increment, so that beat's flags are discarded.
- Reset (asynchronous, any time, including mid-stream):
  - S1/S2 valid, out_valid, out_last, out_llr and sat_cnt all go to 0.
  - in_ready = 1 once rst_n is high.
  - In-flight beats are discarded.
- The mode is captured per beat, so F and G beats may interleave back-to-back.

Test Plan:
1. LLR_W=6, LANES=4, F mode, out_ready=1.
   - Stimulus: lanes (a,b) = (-5,7), (12,-3), (-9,-9), (0,-17).
   - Required: out_llr = (-5, -3, 9, 0) exactly 2 cycles later; sat_cnt unchanged.
2. F mode symmetric saturation.
   - Stimulus: (a,b) = (-32,-32), (-32,10), (31,-32), (-32,0).
   - Required: out_llr = (31, -10, -31, 0); sat_cnt increments by 4.
3. G mode.
   - Stimulus: (a,b,u) = (20,20,0), (20,20,1), (-32,-32,0), (-32,5,1).
   - Required: out_llr = (31, 0, -31, 31); sat_cnt increments by 3.
4. Backpressure, F/G interleaved.
   - Stimulus: 5 back-to-back beats with out_ready=0 for the first 4 cycles.
   - Required: in_ready=0 after 2 beats are accepted; out_llr stable while stalled; all 5 beats emerge in order with correct out_last; no loss.
5. Counter boundaries.
   - Preload sat_cnt to 0xFFFE via saturating beats, then deliver a 4-flag beat -> sat_cnt = 0xFFFF.
   - Assert sat_cnt_clr in the same cycle as a flagged transfer -> sat_cnt = 0.
6. Mid-stream reset.
   - Stimulus: assert rst_n=0 asynchronously with both stages full.
   - Required: out_valid, out_llr and sat_cnt read 0 immediately; after release in_ready=1; the next beat appears after 2 cycles with correct values.
